// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline-control definitions: FSM encodings, NOP constants and opcodes
// used by the hazard control unit and its neighbours.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_LOAD_STALL   = 2'd1,
    ST_MEM_WAIT     = 2'd2,
    ST_BRANCH_FLUSH = 2'd3
  } hcu_state_e;

  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

  // addi x0,x0,0 is what a flushed or bubbled slot carries.
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam int          CNT_WIDTH  = 16;

  function automatic logic src_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side signals seen by the hazard control unit; the pipeline (master)
// drives stage status, the unit (slave) returns stall/flush controls and status.
interface hazard_control_unit_if;
  logic [4:0]  dec_rs1_index;
  logic [4:0]  dec_rs2_index;
  logic        dec_uses_rs1;
  logic        dec_uses_rs2;
  logic        exe_mem_read;
  logic [4:0]  exe_rd_index;
  logic        exe_branch_signal;
  logic        mem_req_valid;
  logic        mem_ack;
  logic        stall_fetch;
  logic        stall_decode;
  logic        bubble_execute;
  logic        freeze_pipeline;
  logic        flush_fetch;
  logic        flush_decode;
  logic [1:0]  hcu_state;
  logic [15:0] stall_cycle_count;
  logic [15:0] flush_count;

  modport master (
    output dec_rs1_index, dec_rs2_index, dec_uses_rs1, dec_uses_rs2,
           exe_mem_read, exe_rd_index, exe_branch_signal, mem_req_valid, mem_ack,
    input  stall_fetch, stall_decode, bubble_execute, freeze_pipeline,
           flush_fetch, flush_decode, hcu_state, stall_cycle_count, flush_count
  );

  modport slave (
    input  dec_rs1_index, dec_rs2_index, dec_uses_rs1, dec_uses_rs2,
           exe_mem_read, exe_rd_index, exe_branch_signal, mem_req_valid, mem_ack,
    output stall_fetch, stall_decode, bubble_execute, freeze_pipeline,
           flush_fetch, flush_decode, hcu_state, stall_cycle_count, flush_count
  );
endinterface

// File: rtl/hcu_sat_counter.sv
// Event counter with async active-low clear; SATURATE selects holding at
// all-ones versus wrapping.
module hcu_sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !(SATURATE && (&count))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and memory-wait
// freezes, with Mealy outputs so the action lands in the detecting cycle.
//
// state           | meaning
// ST_RUN          | normal flow, watching for branch / load-use
// ST_LOAD_STALL   | second bubble of a load-use stall
// ST_MEM_WAIT     | memory access outstanding, whole pipe frozen
// ST_BRANCH_FLUSH | one more decode flush for the fetch latency
module hazard_control_unit
  import hazard_control_unit_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  hazard_control_unit_if.slave hcu
);

  hcu_state_e state, state_nxt, ret_state, ret_nxt, eff_state;
  logic load_use, mem_block, flush_inc, stall_inc;
  logic stall_fetch, stall_decode, bubble_execute, freeze_pipeline;
  logic flush_fetch, flush_decode;

  assign load_use = hcu.exe_mem_read && (hcu.exe_rd_index != REG_ZERO) &&
                    (src_match(hcu.dec_uses_rs1, hcu.dec_rs1_index, hcu.exe_rd_index) ||
                     src_match(hcu.dec_uses_rs2, hcu.dec_rs2_index, hcu.exe_rd_index));
  assign mem_block = hcu.mem_req_valid && !hcu.mem_ack;

  // Leaving a memory wait resumes the interrupted state's rules in the same cycle.
  assign eff_state = (state == ST_MEM_WAIT) ? ret_state : state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ret_nxt         = ret_state;
    stall_fetch     = 1'b0;
    stall_decode    = 1'b0;
    bubble_execute  = 1'b0;
    freeze_pipeline = 1'b0;
    flush_fetch     = 1'b0;
    flush_decode    = 1'b0;
    flush_inc       = 1'b0;
    if (mem_block) begin
      freeze_pipeline = 1'b1;
      state_nxt       = ST_MEM_WAIT;
      if (state != ST_MEM_WAIT) ret_nxt = state;
    end else begin
      case (eff_state)
        ST_RUN: begin
          if (hcu.exe_branch_signal) begin
            flush_fetch  = 1'b1;
            flush_decode = 1'b1;
            flush_inc    = 1'b1;
            state_nxt    = ST_BRANCH_FLUSH;
          end else if (load_use) begin
            stall_fetch    = 1'b1;
            stall_decode   = 1'b1;
            bubble_execute = 1'b1;
            state_nxt      = ST_LOAD_STALL;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_LOAD_STALL: begin
          stall_fetch    = 1'b1;
          stall_decode   = 1'b1;
          bubble_execute = 1'b1;
          state_nxt      = ST_RUN;
        end
        ST_BRANCH_FLUSH: begin
          flush_decode = 1'b1;
          state_nxt    = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
    // Under reset only the memory freeze may follow live inputs.
    if (!rst) begin
      stall_fetch    = 1'b0;
      stall_decode   = 1'b0;
      bubble_execute = 1'b0;
      flush_fetch    = 1'b0;
      flush_decode   = 1'b0;
      flush_inc      = 1'b0;
    end
  end

  assign stall_inc = stall_fetch | freeze_pipeline;

  hcu_sat_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b1)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (hcu.stall_cycle_count)
  );

  hcu_sat_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b0)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (hcu.flush_count)
  );

  assign hcu.stall_fetch     = stall_fetch;
  assign hcu.stall_decode    = stall_decode;
  assign hcu.bubble_execute  = bubble_execute;
  assign hcu.freeze_pipeline = freeze_pipeline;
  assign hcu.flush_fetch     = flush_fetch;
  assign hcu.flush_decode    = flush_decode;
  assign hcu.hcu_state       = state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: stimulus table plus hand-built
// multi-cycle sequences, expectations queued at drive time and popped at sample.
module tb_hazard_control_unit;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        ld;
    logic [4:0]  rd;
    logic        br;
    logic        mreq;
    logic        mack;
    logic [5:0]  outs;   // {stall_fetch, stall_decode, bubble_execute, freeze, flush_fetch, flush_decode}
    logic [1:0]  st;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } vec_t;

  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_STALL = 6'b111000;
  localparam logic [5:0] O_FRZ   = 6'b000100;
  localparam logic [5:0] O_FL2   = 6'b000011;
  localparam logic [5:0] O_FLD   = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  vec_t exp_q[$];
  vec_t tbl[19];

  hazard_control_unit_if bus();

  hazard_control_unit dut (
    .clk (clk),
    .rst (rst),
    .hcu (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic ld,
                              input logic [4:0] rd, input logic br, input logic mreq,
                              input logic mack, input logic [5:0] outs,
                              input logic [1:0] st, input logic [15:0] scnt,
                              input logic [15:0] fcnt);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ld = ld; v.rd = rd;
    v.br = br; v.mreq = mreq; v.mack = mack;
    v.outs = outs; v.st = st; v.scnt = scnt; v.fcnt = fcnt;
    return v;
  endfunction

  function automatic vec_t idle(input logic [5:0] outs, input logic [1:0] st,
                                input logic [15:0] scnt, input logic [15:0] fcnt);
    return mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, outs, st, scnt, fcnt);
  endfunction

  task automatic drive(input vec_t v);
    bus.dec_rs1_index     = v.rs1;
    bus.dec_rs2_index     = v.rs2;
    bus.dec_uses_rs1      = v.u1;
    bus.dec_uses_rs2      = v.u2;
    bus.exe_mem_read      = v.ld;
    bus.exe_rd_index      = v.rd;
    bus.exe_branch_signal = v.br;
    bus.mem_req_valid     = v.mreq;
    bus.mem_ack           = v.mack;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic compare_now(input vec_t e, input string tag);
    logic [5:0] act;
    act = {bus.stall_fetch, bus.stall_decode, bus.bubble_execute,
           bus.freeze_pipeline, bus.flush_fetch, bus.flush_decode};
    check({tag, " outs"}, {26'd0, act}, {26'd0, e.outs});
    check({tag, " state"}, {30'd0, bus.hcu_state}, {30'd0, e.st});
    check({tag, " counts"}, {bus.stall_cycle_count, bus.flush_count}, {e.scnt, e.fcnt});
  endtask

  // Drive one cycle of stimulus, sample the combinational response mid-cycle.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      compare_now(e, tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input vec_t v, input string tag);
    rst = 1'b0;
    drive(v);
    #1;
    compare_now(v, tag);
    drive(idle(O_NONE, 2'd0, 16'd0, 16'd0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    drive(idle(O_NONE, 2'd0, 16'd0, 16'd0));
    @(posedge clk);
    #1;

    // Reset with a memory block, branch and load-use all live: only freeze follows.
    apply_reset(mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0,
                   O_FRZ, 2'd0, 16'd0, 16'd0), "rst_live_mem");

    tbl[0]  = idle(O_NONE, 2'd0, 16'd0, 16'd0);
    tbl[1]  = mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0, 16'd0, 16'd0);
    tbl[2]  = mk(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_STALL, 2'd0, 16'd0, 16'd0);
    tbl[3]  = mk(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_STALL, 2'd1, 16'd1, 16'd0);
    tbl[4]  = idle(O_NONE, 2'd0, 16'd2, 16'd0);
    tbl[5]  = mk(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_STALL, 2'd0, 16'd2, 16'd0);
    tbl[6]  = idle(O_STALL, 2'd1, 16'd3, 16'd0);
    tbl[7]  = mk(5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0, 16'd4, 16'd0);
    tbl[8]  = mk(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0, 16'd4, 16'd0);
    tbl[9]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_FL2, 2'd0, 16'd4, 16'd0);
    tbl[10] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_FLD, 2'd3, 16'd4, 16'd1);
    tbl[11] = idle(O_NONE, 2'd0, 16'd4, 16'd1);
    tbl[12] = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_FL2, 2'd0, 16'd4, 16'd1);
    tbl[13] = idle(O_FLD, 2'd3, 16'd4, 16'd2);
    tbl[14] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_NONE, 2'd0, 16'd4, 16'd2);
    tbl[15] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FRZ, 2'd0, 16'd4, 16'd2);
    tbl[16] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, O_FL2, 2'd2, 16'd5, 16'd2);
    tbl[17] = idle(O_FLD, 2'd3, 16'd5, 16'd3);
    tbl[18] = idle(O_NONE, 2'd0, 16'd5, 16'd3);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset while branch and load-use are live: no flush or bubble may escape.
    apply_reset(mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0,
                   O_NONE, 2'd0, 16'd0, 16'd0), "rst_live_flush");

    // Classic load-use: lw x5 then add x6,x5,x1.
    v = mk(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_STALL, 2'd0, 16'd0, 16'd0);
    step(v, "lu_c1");
    v.st = 2'd1; v.scnt = 16'd1;
    step(v, "lu_c2");
    step(idle(O_NONE, 2'd0, 16'd2, 16'd0), "lu_done");

    // Memory wait inside a load stall resumes the second bubble afterwards.
    apply_reset(idle(O_NONE, 2'd0, 16'd0, 16'd0), "rst_mw");
    step(mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_STALL, 2'd0, 16'd0, 16'd0), "mw_b1");
    v = idle(O_FRZ, 2'd1, 16'd1, 16'd0);
    v.mreq = 1'b1;
    step(v, "mw_f1");
    v.st = 2'd2; v.scnt = 16'd2;
    step(v, "mw_f2");
    v.scnt = 16'd3;
    step(v, "mw_f3");
    step(idle(O_STALL, 2'd2, 16'd4, 16'd0), "mw_b2");
    step(idle(O_NONE, 2'd0, 16'd5, 16'd0), "mw_done");

    // Reset in the middle of a branch flush.
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_FL2, 2'd0, 16'd5, 16'd0), "bf_c1");
    apply_reset(idle(O_NONE, 2'd0, 16'd0, 16'd0), "rst_in_bf");
    step(idle(O_NONE, 2'd0, 16'd0, 16'd0), "bf_after");

    // Reset in the middle of a load stall.
    step(mk(5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, O_STALL, 2'd0, 16'd0, 16'd0), "ls_c1");
    apply_reset(idle(O_NONE, 2'd0, 16'd0, 16'd0), "rst_in_ls");
    step(idle(O_NONE, 2'd0, 16'd0, 16'd0), "ls_after");

    // Long freeze drives the stall counter into saturation.
    v = idle(O_FRZ, 2'd2, 16'hFFFF, 16'd0);
    v.mreq = 1'b1;
    drive(v);
    repeat (65540) @(posedge clk);
    #1;
    step(v, "sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: dec_rs1_index, dec_rs2_index  input  5 each  source register indices of the instruction in decode.
REQ-004 SHALL have ports: dec_uses_rs1, dec_uses_rs2  input  1 each  decode instruction actually reads rs1/rs2.
REQ-005 SHALL have ports: exe_mem_read  input  1  instruction in execute is a load; exe_rd_index  input  5  its destination.
REQ-006 SHALL have port: exe_branch_signal  input  1  execute stage redirects the PC this cycle.
REQ-007 SHALL have ports: mem_req_valid  input  1  mem stage issues an access; mem_ack  input  1  access completes this cycle.
REQ-008 SHALL have ports: stall_fetch, stall_decode  output  1 each  hold PC / fetch-to-decode register.
REQ-009 SHALL have ports: bubble_execute  output  1  load NOP into decode-to-execute register; freeze_pipeline  output  1  hold every pipeline register.
REQ-010 SHALL have ports: flush_fetch, flush_decode  output  1 each  replace fetched/decoded instruction with NOP.
REQ-011 SHALL have ports: hcu_state  output  2  current FSM state; stall_cycle_count  output  16; flush_count  output  16.

Function
REQ-012 SHALL implement FSM states RUN=0, LOAD_STALL=1, MEM_WAIT=2, BRANCH_FLUSH=3.
REQ-013 SHALL define load_use = exe_mem_read & exe_rd_index!=0 & ((dec_uses_rs1 & dec_rs1_index==exe_rd_index) | (dec_uses_rs2 & dec_rs2_index==exe_rd_index)), combinational.
REQ-014 SHALL define mem_block = mem_req_valid & ~mem_ack.
REQ-015 SHALL give per-cycle priority: mem_block > exe_branch_signal > load_use; outputs are combinational (Mealy) from state and inputs, so action takes effect in the detecting cycle.
REQ-016 In any state, mem_block SHALL assert freeze_pipeline only (all other outputs 0), save the current state to a return register (unless already MEM_WAIT), and enter/stay MEM_WAIT.
REQ-017 In MEM_WAIT with ~mem_block, SHALL deassert freeze_pipeline in that cycle and evaluate the saved return state's rules (REQ-018..020) for that cycle.
REQ-018 RUN: exe_branch_signal SHALL assert flush_fetch and flush_decode and enter BRANCH_FLUSH; else load_use SHALL assert stall_fetch, stall_decode, bubble_execute and enter LOAD_STALL; else all outputs 0, stay RUN.
REQ-019 LOAD_STALL SHALL assert stall_fetch, stall_decode, bubble_execute for exactly one more cycle (total two bubbles, since mem-stage loads are not forwarded) then return RUN, ignoring load_use in that cycle.
REQ-020 BRANCH_FLUSH SHALL assert flush_decode for one cycle (synchronous instruction-memory latency), ignore exe_branch_signal, then return RUN.
REQ-021 stall_cycle_count SHALL increment by 1 each cycle stall_fetch | freeze_pipeline is high, saturating at 16'hFFFF.
REQ-022 flush_count SHALL increment by 1 on each RUN-to-BRANCH_FLUSH transition, wrapping modulo 2^16.
REQ-023 mem_req_valid with mem_ack in the same cycle SHALL cause no stall.

Reset
REQ-024 rst low SHALL immediately force state RUN, return register RUN, both counters 0; all outputs SHALL then read 0 except as REQ-016 dictates from live inputs.
REQ-025 Reset asserted mid-stall or mid-flush SHALL abandon the sequence with no residual bubble after release.

Structure
REQ-026 State encodings and NOP-related constants SHALL live in the shared common header alongside the opcode definitions.
REQ-027 One sub-module, hcu_sat_counter (16-bit, saturate/wrap selectable by parameter), SHALL be instantiated twice for the counters.

Verification
REQ-028 Load x5 in execute, decode add x6,x5,x1 (uses_rs1) -> bubble_execute high 2 consecutive cycles, hcu_state 1 in second, then RUN; stall_cycle_count=2.
REQ-029 Load with exe_rd_index=0, dec_rs1_index=0 -> no stall, all outputs 0.
REQ-030 exe_branch_signal pulse in RUN -> flush_fetch+flush_decode cycle 1, flush_decode only cycle 2, flush_count=1.
REQ-031 mem_req_valid high, mem_ack low 3 cycles during LOAD_STALL -> freeze_pipeline 3 cycles, then one LOAD_STALL cycle, then RUN; stall_cycle_count=5 including the first bubble.
REQ-032 exe_branch_signal and load_use simultaneously -> branch flush only, no bubble_execute.
REQ-033 rst low during BRANCH_FLUSH, release -> hcu_state 0, counters 0, no flush output.
